// File: rtl/hazard_sb_unit.sv
// Hazard unit for the five-stage core: load-use and long-latency stalls, redirect flushes, EX forwarding.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_sb_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  rs1_used_id,
    input  logic                  rs2_used_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  regwrite_id,
    input  logic [REG_ADDR_W-1:0] rs1_ex,
    input  logic [REG_ADDR_W-1:0] rs2_ex,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic [1:0]            result_src_ex,
    input  logic                  redirect_ex,
    input  logic                  lla_issue,
    input  logic [REG_ADDR_W-1:0] lla_rd,
    input  logic                  lla_done,
    input  logic [REG_ADDR_W-1:0] lla_done_rd,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  regwrite_mem,
    input  logic                  regwrite_wb,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic [1:0]            fwd_a_ex,
    output logic [1:0]            fwd_b_ex,
    output logic                  sb_busy,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
);
    localparam int                  NREG        = 1 << REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG  = {REG_ADDR_W{1'b0}};
    localparam logic [2:0]          SHADOW_INIT = 3'(LOAD_LAT - 1);

    logic [NREG-1:0]       pending_q, pending_d;
    logic [2:0]            shadow_cnt_q, shadow_cnt_d;
    logic [REG_ADDR_W-1:0] shadow_rd_q, shadow_rd_d;
    logic                  load_haz_s, sb_haz_s, stall_s;

    function automatic logic src_match(input logic used, input logic [REG_ADDR_W-1:0] src,
                                       input logic [REG_ADDR_W-1:0] target);
        return used && (src != ZERO_REG) && (src == target);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
        if ((src != ZERO_REG) && regwrite_mem && (src == rd_mem)) begin
            return 2'b10;
        end else if ((src != ZERO_REG) && regwrite_wb && (src == rd_wb)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // A register is blocked if already pending or being issued this very cycle
    function automatic logic reg_blocked(input logic [REG_ADDR_W-1:0] r);
        return pending_q[r] || (lla_issue && (r == lla_rd));
    endfunction

    // Hazard detection from decode sources against loads and the scoreboard
    always_comb begin
        load_haz_s = 1'b0;
        sb_haz_s   = 1'b0;
        if ((result_src_ex == 2'b01) && (rd_ex != ZERO_REG)) begin
            load_haz_s = src_match(rs1_used_id, rs1_id, rd_ex) || src_match(rs2_used_id, rs2_id, rd_ex);
        end else begin
            load_haz_s = 1'b0;
        end
        if (shadow_cnt_q != 3'd0) begin
            load_haz_s = load_haz_s || src_match(rs1_used_id, rs1_id, shadow_rd_q)
                                    || src_match(rs2_used_id, rs2_id, shadow_rd_q);
        end else begin
            load_haz_s = load_haz_s;
        end
        sb_haz_s = (rs1_used_id && (rs1_id != ZERO_REG) && reg_blocked(rs1_id))
                || (rs2_used_id && (rs2_id != ZERO_REG) && reg_blocked(rs2_id))
                || (regwrite_id && (rd_id != ZERO_REG) && reg_blocked(rd_id));
        stall_s  = (load_haz_s || sb_haz_s) && !redirect_ex;
    end

    // Output drive; everything is held quiet while reset is asserted
    always_comb begin
        if (rst) begin
            stall_if = 1'b0;
            stall_id = 1'b0;
            flush_id = 1'b0;
            flush_ex = 1'b0;
            fwd_a_ex = 2'b00;
            fwd_b_ex = 2'b00;
        end else begin
            stall_if = stall_s;
            stall_id = stall_s;
            flush_id = redirect_ex;
            flush_ex = stall_s || redirect_ex;
            fwd_a_ex = fwd_sel(rs1_ex);
            fwd_b_ex = fwd_sel(rs2_ex);
        end
        sb_busy = |pending_q;
    end

    // Next state for the scoreboard and the load shadow (issue beats completion on the same register)
    always_comb begin
        pending_d = pending_q;
        if (lla_done) begin
            pending_d[lla_done_rd] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
        if (lla_issue && (lla_rd != ZERO_REG)) begin
            pending_d[lla_rd] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;

        if (result_src_ex == 2'b01) begin
            shadow_cnt_d = SHADOW_INIT;
            shadow_rd_d  = rd_ex;
        end else if (shadow_cnt_q != 3'd0) begin
            shadow_cnt_d = shadow_cnt_q - 3'd1;
            shadow_rd_d  = shadow_rd_q;
        end else begin
            shadow_cnt_d = shadow_cnt_q;
            shadow_rd_d  = shadow_rd_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= {NREG{1'b0}};
            shadow_cnt_q <= 3'd0;
            shadow_rd_q  <= ZERO_REG;
        end else begin
            pending_q    <= pending_d;
            shadow_cnt_q <= shadow_cnt_d;
            shadow_rd_q  <= shadow_rd_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    // Free-running wrap-around event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_q + {31'd0, stall_s};
            perf_flush_q <= perf_flush_q + {31'd0, redirect_ex};
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_sb_unit.sv
// Bench for hazard_sb_unit: two instances (LOAD_LAT 1 and 3) against a cycle-stamped reference model.
module tb_hazard_sb_unit;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1_id, rs2_id, rd_id, rs1_ex, rs2_ex, rd_ex, lla_rd, lla_done_rd, rd_mem, rd_wb;
    logic rs1_used_id, rs2_used_id, regwrite_id, redirect_ex, lla_issue, lla_done;
    logic regwrite_mem, regwrite_wb;
    logic [1:0] result_src_ex;

    logic        st_if[2], st_id[2], fl_id[2], fl_ex[2], busy[2];
    logic [1:0]  fa[2], fb[2];
    logic [31:0] pst[2], pfl[2];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // reference model state
    int  cyc = 0;
    bit  ld_seen;
    int  ld_cyc;
    logic [4:0] ld_rd;
    bit  pend[32];
    int  m_pst[2], m_pfl[2];
    int  lat[2] = '{1, 3};

    always #5 clk = ~clk;

    hazard_sb_unit #(.REG_ADDR_W(5), .LOAD_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id),
        .rs2_used_id(rs2_used_id), .rd_id(rd_id), .regwrite_id(regwrite_id), .rs1_ex(rs1_ex),
        .rs2_ex(rs2_ex), .rd_ex(rd_ex), .result_src_ex(result_src_ex), .redirect_ex(redirect_ex),
        .lla_issue(lla_issue), .lla_rd(lla_rd), .lla_done(lla_done), .lla_done_rd(lla_done_rd),
        .rd_mem(rd_mem), .rd_wb(rd_wb), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
        .stall_if(st_if[0]), .stall_id(st_id[0]), .flush_id(fl_id[0]), .flush_ex(fl_ex[0]),
        .fwd_a_ex(fa[0]), .fwd_b_ex(fb[0]), .sb_busy(busy[0]),
        .perf_stall_cnt(pst[0]), .perf_flush_cnt(pfl[0]));

    hazard_sb_unit #(.REG_ADDR_W(5), .LOAD_LAT(3)) u_l3 (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id),
        .rs2_used_id(rs2_used_id), .rd_id(rd_id), .regwrite_id(regwrite_id), .rs1_ex(rs1_ex),
        .rs2_ex(rs2_ex), .rd_ex(rd_ex), .result_src_ex(result_src_ex), .redirect_ex(redirect_ex),
        .lla_issue(lla_issue), .lla_rd(lla_rd), .lla_done(lla_done), .lla_done_rd(lla_done_rd),
        .rd_mem(rd_mem), .rd_wb(rd_wb), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
        .stall_if(st_if[1]), .stall_id(st_id[1]), .flush_id(fl_id[1]), .flush_ex(fl_ex[1]),
        .fwd_a_ex(fa[1]), .fwd_b_ex(fb[1]), .sb_busy(busy[1]),
        .perf_stall_cnt(pst[1]), .perf_flush_cnt(pfl[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit dep(input logic [4:0] t);
        return (rs1_used_id && rs1_id != 5'd0 && rs1_id == t) ||
               (rs2_used_id && rs2_id != 5'd0 && rs2_id == t);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] s);
        if (s == 5'd0) return 2'b00;
        if (regwrite_mem && s == rd_mem) return 2'b10;
        if (regwrite_wb && s == rd_wb) return 2'b01;
        return 2'b00;
    endfunction

    // data of a load seen in EX at cycle c is forwardable from cycle c+L onward
    function automatic bit m_stall(input int L);
        bit h = 1'b0;
        if (result_src_ex == 2'b01 && rd_ex != 5'd0 && dep(rd_ex)) h = 1'b1;
        if (ld_seen && cyc > ld_cyc && cyc < ld_cyc + L && dep(ld_rd)) h = 1'b1;
        for (int r = 1; r < 32; r++) begin
            if (pend[r] || (lla_issue && lla_rd == 5'(r))) begin
                if (dep(5'(r))) h = 1'b1;
                if (regwrite_id && rd_id == 5'(r)) h = 1'b1;
            end
        end
        return h && !redirect_ex;
    endfunction

    function automatic bit m_busy();
        for (int r = 0; r < 32; r++) if (pend[r]) return 1'b1;
        return 1'b0;
    endfunction

    // model advance on each rising edge, using the inputs present at that edge
    always @(posedge clk) begin
        if (rst) begin
            ld_seen = 1'b0;
            for (int r = 0; r < 32; r++) pend[r] = 1'b0;
            for (int i = 0; i < 2; i++) begin m_pst[i] = 0; m_pfl[i] = 0; end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_stall(lat[i])) m_pst[i]++;
                if (redirect_ex) m_pfl[i]++;
            end
            if (result_src_ex == 2'b01) begin ld_seen = 1'b1; ld_cyc = cyc; ld_rd = rd_ex; end
            if (lla_done) pend[lla_done_rd] = 1'b0;
            if (lla_issue && lla_rd != 5'd0) pend[lla_rd] = 1'b1;
        end
        cyc++;
    end

    // per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                bit s;
                s = rst ? 1'b0 : m_stall(lat[i]);
                chk("stall_if", {31'd0, st_if[i]}, {31'd0, s});
                chk("stall_id", {31'd0, st_id[i]}, {31'd0, s});
                chk("flush_ex", {31'd0, fl_ex[i]}, {31'd0, !rst && (s || redirect_ex)});
                chk("flush_id", {31'd0, fl_id[i]}, {31'd0, !rst && redirect_ex});
                chk("fwd_a", {30'd0, fa[i]}, {30'd0, rst ? 2'b00 : m_fwd(rs1_ex)});
                chk("fwd_b", {30'd0, fb[i]}, {30'd0, rst ? 2'b00 : m_fwd(rs2_ex)});
                chk("sb_busy", {31'd0, busy[i]}, {31'd0, m_busy()});
`ifdef HAZARD_PERF_EN
                chk("perf_stall", pst[i], 32'(m_pst[i]));
                chk("perf_flush", pfl[i], 32'(m_pfl[i]));
`else
                chk("perf_stall", pst[i], 32'd0);
                chk("perf_flush", pfl[i], 32'd0);
`endif
            end
        end
    end

    task automatic idle();
        rs1_id = 5'd0; rs2_id = 5'd0; rd_id = 5'd0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
        regwrite_id = 1'b0; rs1_ex = 5'd0; rs2_ex = 5'd0; rd_ex = 5'd0; result_src_ex = 2'b00;
        redirect_ex = 1'b0; lla_issue = 1'b0; lla_rd = 5'd0; lla_done = 1'b0; lla_done_rd = 5'd0;
        rd_mem = 5'd0; rd_wb = 5'd0; regwrite_mem = 1'b0; regwrite_wb = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        next();
        chk_en = 1'b1;
        // forwarding sources present during reset must not leak
        rd_mem = 5'd5; regwrite_mem = 1'b1; rs1_ex = 5'd5;
        at_neg();
        chk("rst_fwd_a", {30'd0, fa[0]}, 32'd0);
        chk("rst_stall", {31'd0, st_id[1]}, 32'd0);
        next();
        rst = 1'b0;
        idle();
        at_neg();
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);

        // forwarding: MEM priority, zero register, WB only
        next();
        rd_mem = 5'd5; regwrite_mem = 1'b1; rd_wb = 5'd5; regwrite_wb = 1'b1;
        rs1_ex = 5'd5; rs2_ex = 5'd5;
        at_neg();
        chk("fwd_mem_a", {30'd0, fa[0]}, 32'd2);
        chk("fwd_mem_b", {30'd0, fb[1]}, 32'd2);
        next();
        rs1_ex = 5'd0; rs2_ex = 5'd0;
        at_neg();
        chk("fwd_x0", {30'd0, fa[0]}, 32'd0);
        next();
        rs1_ex = 5'd5; rs2_ex = 5'd5; rd_mem = 5'd6;
        at_neg();
        chk("fwd_wb", {30'd0, fb[0]}, 32'd1);

        // load immediately ahead of its consumer
        next();
        idle();
        result_src_ex = 2'b01; rd_ex = 5'd3; rs2_id = 5'd3; rs2_used_id = 1'b1;
        at_neg();
        chk("ld1_c0", {31'd0, st_if[0]}, 32'd1);
        chk("ld1_fex", {31'd0, fl_ex[0]}, 32'd1);
        chk("ld3_c0", {31'd0, st_id[1]}, 32'd1);
        next();
        result_src_ex = 2'b00; rd_ex = 5'd0;
        at_neg();
        chk("ld1_c1", {31'd0, st_id[0]}, 32'd0);
        chk("ld3_c1", {31'd0, st_id[1]}, 32'd1);
        next();
        at_neg();
        chk("ld3_c2", {31'd0, st_id[1]}, 32'd1);
        next();
        at_neg();
        chk("ld3_c3", {31'd0, st_id[1]}, 32'd0);

        // one intervening instruction: LOAD_LAT-1 stall cycles
        next();
        idle();
        result_src_ex = 2'b01; rd_ex = 5'd3;
        next();
        idle();
        rs1_id = 5'd3; rs1_used_id = 1'b1;
        at_neg();
        chk("gap_l1", {31'd0, st_id[0]}, 32'd0);
        chk("gap_l3_a", {31'd0, st_id[1]}, 32'd1);
        next();
        at_neg();
        chk("gap_l3_b", {31'd0, st_id[1]}, 32'd1);
        next();
        at_neg();
        chk("gap_l3_c", {31'd0, st_id[1]}, 32'd0);

        // redirect dominates a load-use hazard
        next();
        idle();
        result_src_ex = 2'b01; rd_ex = 5'd4; rs1_id = 5'd4; rs1_used_id = 1'b1; redirect_ex = 1'b1;
        at_neg();
        chk("redir_stall", {31'd0, st_id[0]}, 32'd0);
        chk("redir_fid", {31'd0, fl_id[1]}, 32'd1);
        chk("redir_fex", {31'd0, fl_ex[1]}, 32'd1);
        next();
        idle();
        redirect_ex = 1'b1;
        next();
        idle();

        // long-latency op on x7 with a dependent in decode
        next();
        lla_issue = 1'b1; lla_rd = 5'd7; rs1_id = 5'd7; rs1_used_id = 1'b1;
        at_neg();
        chk("lla_issue_stall", {31'd0, st_id[0]}, 32'd1);
        next();
        lla_issue = 1'b0;
        at_neg();
        chk("lla_busy", {31'd0, busy[0]}, 32'd1);
        chk("lla_pend_stall", {31'd0, st_if[1]}, 32'd1);
        next();
        lla_done = 1'b1; lla_done_rd = 5'd7;
        at_neg();
        chk("lla_done_stall", {31'd0, st_id[0]}, 32'd1);
        next();
        lla_done = 1'b0;
        at_neg();
        chk("lla_release", {31'd0, st_id[0]}, 32'd0);
        chk("lla_idle", {31'd0, busy[1]}, 32'd0);

        // write-after-write against an issuing op
        next();
        idle();
        lla_issue = 1'b1; lla_rd = 5'd8; regwrite_id = 1'b1; rd_id = 5'd8;
        at_neg();
        chk("waw_stall", {31'd0, st_id[1]}, 32'd1);
        next();
        lla_issue = 1'b0; lla_done = 1'b1; lla_done_rd = 5'd8;
        next();
        idle();
        at_neg();
        chk("waw_clear", {31'd0, st_id[1]}, 32'd0);

        // set and clear of x9 together: set wins; reset then drops it
        next();
        lla_issue = 1'b1; lla_rd = 5'd9; lla_done = 1'b1; lla_done_rd = 5'd9;
        next();
        idle();
        at_neg();
        chk("setwins_busy", {31'd0, busy[0]}, 32'd1);
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        lla_done = 1'b1; lla_done_rd = 5'd9;
        at_neg();
        chk("rst_drop_busy", {31'd0, busy[0]}, 32'd0);

        // four stall cycles then two redirects
        next();
        idle();
        lla_issue = 1'b1; lla_rd = 5'd10; rs1_id = 5'd10; rs1_used_id = 1'b1;
        next();
        lla_issue = 1'b0;
        next();
        next();
        lla_done = 1'b1; lla_done_rd = 5'd10;
        next();
        idle();
        redirect_ex = 1'b1;
        next();
        next();
        idle();
        at_neg();
`ifdef HAZARD_PERF_EN
        chk("perf_stall_lit", pst[1], 32'd4);
        chk("perf_flush_lit", pfl[0], 32'd2);
`else
        chk("perf_stall_lit", pst[1], 32'd0);
        chk("perf_flush_lit", pfl[0], 32'd0);
`endif
        next();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_sb_unit.md
# hazard_sb_unit

Parametrised hazard unit for the in-order five-stage core: it replaces the purely combinational load-use/forwarding logic. It generates fetch/decode stall, decode/execute flush and EX operand-forwarding selects, and handles loads whose data arrive more than one cycle after EX. A per-register scoreboard tracks destinations of long-latency (divider/multi-cycle) ops issued from EX. It sits beside the pipeline registers and drives their stall/flush controls.

## Interface
- REG_ADDR_W, 5, register address width; scoreboard holds 2**REG_ADDR_W bits
- LOAD_LAT, 1, cycles from load in EX until its data can be forwarded (legal 1..4)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rs1_id, rs2_id  in  REG_ADDR_W  decode source addresses
- rs1_used_id, rs2_used_id  in  1  source actually read by decode instruction
- rd_id  in  REG_ADDR_W  decode destination
- regwrite_id  in  1  decode instruction writes rd
- rs1_ex, rs2_ex  in  REG_ADDR_W  execute source addresses
- rd_ex  in  REG_ADDR_W  execute destination
- result_src_ex  in  2  2'b01 = load in EX
- redirect_ex  in  1  taken branch/jump resolved in EX
- lla_issue  in  1  long-latency op leaves EX this cycle
- lla_rd  in  REG_ADDR_W  its destination
- lla_done  in  1  long-latency result written back this cycle
- lla_done_rd  in  REG_ADDR_W  completing destination
- rd_mem, rd_wb  in  REG_ADDR_W  MEM/WB destinations
- regwrite_mem, regwrite_wb  in  1  MEM/WB write enables
- stall_if, stall_id  out  1  hold PC / IF-ID register
- flush_id, flush_ex  out  1  bubble IF-ID / ID-EX register
- fwd_a_ex, fwd_b_ex  out  2  operand select: 00 regfile, 10 MEM, 01 WB
- sb_busy  out  1  any scoreboard bit set
- perf_stall_cnt, perf_flush_cnt  out  32  performance counters

## Operation
- Forwarding (combinational, identical rule for A and B): src != 0 & regwrite_mem & src == rd_mem -> 10; else src != 0 & regwrite_wb & src == rd_wb -> 01; else 00. MEM has priority.
- Match(r) for a decode source = used & r != 0 & r == target.
- Load hazard: result_src_ex == 01 & rd_ex != 0 & Match(rs1_id|rs2_id, rd_ex); or shadow_cnt != 0 & Match(…, shadow_rd).
- Load shadow: registered shadow_rd/shadow_cnt. Cycle a load sits in EX: next shadow_cnt = LOAD_LAT-1, shadow_rd = rd_ex. Otherwise decrement while nonzero. LOAD_LAT=1: shadow never nonzero. A repeated load in EX reloads it.
- Scoreboard: pending[2**REG_ADDR_W]. lla_issue & lla_rd != 0 sets pending[lla_rd] next cycle. lla_done clears pending[lla_done_rd]. Same register set and clear same cycle -> set wins. pending[0] always 0.
- Scoreboard hazard: Match(src, r) with pending[r] or (lla_issue & r == lla_rd). Also WAW: regwrite_id & rd_id != 0 & rd_id pending/issuing.
- stall = (load hazard | scoreboard hazard) & ~redirect_ex.
- stall_if = stall_id = stall; flush_ex = stall | redirect_ex; flush_id = redirect_ex.
- Redirect dominates: decode instruction is discarded, so no stall is issued for it.
- sb_busy = |pending.

## Timing
- All hazard/forward outputs combinational from inputs and registered state; no added latency.
- State update on clk rising edge only.
- rst high: pending, shadow_cnt, shadow_rd and perf counters cleared next edge. While rst is high, stall_*, flush_* forced 0 and fwd_* 00.
- Load dependent in ID stalls exactly LOAD_LAT cycles if the load is immediately ahead. One intervening instruction -> LOAD_LAT-1 cycles.
- Long-latency dependent stalls from issue cycle through the lla_done cycle inclusive. It enters EX the cycle after lla_done and picks up data via WB forwarding or the regfile.
- Reset mid-operation drops all outstanding pending bits; lla_done for a cleared bit is harmless.

## Configuration
- HAZARD_PERF_EN defined: perf_stall_cnt increments every non-reset cycle with stall=1; perf_flush_cnt increments every cycle with redirect_ex=1. Both wrap at 2**32.
- HAZARD_PERF_EN undefined: counters not built; both outputs tied to 0.

## Test plan
- rd_mem=5, regwrite_mem=1, rd_wb=5, regwrite_wb=1, rs1_ex=rs2_ex=5 -> fwd_a_ex=fwd_b_ex=10. Same with rs=0 -> 00.
- LOAD_LAT=1: load rd_ex=3 in EX, rs2_id=3 used -> stall_if=stall_id=flush_ex=1 for 1 cycle. LOAD_LAT=3 -> 3 consecutive stall cycles, then 0.
- Load in EX matching rs1_id with redirect_ex=1 -> stall=0, flush_id=flush_ex=1.
- lla_issue rd=7. Decode reads x7 -> stalls until lla_done_rd=7 and deasserts the following cycle. sb_busy=1 during, 0 after.
- Same cycle lla_issue rd=9 and lla_done rd=9 -> pending[9]=1 afterward. rst asserted with pending set -> sb_busy=0 next cycle.
- HAZARD_PERF_EN defined: 4 stall cycles and 2 redirects -> perf_stall_cnt=4, perf_flush_cnt=2. Undefined -> both 0.
